// File: rtl/vcode_gen.sv
// vcode_gen: transmit-side virtual-code generator.
// Accumulates a CRC over each outgoing frame (FRAME_WIDTH/DWIDTH beats),
// XORs the zero-extended frame ID into it and writes the result into the
// low CRC_WIDTH bits of the frame's last beat. One cycle of latency.
module vcode_gen #(
  parameter int unsigned                 FRAME_WIDTH    = 256,
  parameter int unsigned                 DWIDTH         = 64,
  parameter int unsigned                 CRC_WIDTH      = 12,
  parameter logic [CRC_WIDTH-1:0]        CRC_POLY       = 12'h02f,
  parameter int unsigned                 FRAME_ID_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tx_up,
  input  logic                      sof,
  input  logic [DWIDTH-1:0]         data_in,
  input  logic                      rewind,
  input  logic [FRAME_ID_WIDTH-1:0] rewind_id,
  output logic [DWIDTH-1:0]         data_out,
  output logic                      sof_out,
  output logic                      valid_out,
  output logic [FRAME_ID_WIDTH-1:0] frame_id
);

  localparam int unsigned NBEATS = FRAME_WIDTH / DWIDTH;
  localparam bit          SINGLE = (NBEATS == 1);
  // Keep the counter at least one bit wide so single-beat builds elaborate.
  localparam int unsigned CNT_WIDTH = SINGLE ? 1 : $clog2(NBEATS);

  // One beat of CRC, bits consumed MSB first.
  function automatic logic [CRC_WIDTH-1:0] crc_step(
    input logic [CRC_WIDTH-1:0] c_in,
    input logic [DWIDTH-1:0]    d
  );
    logic [CRC_WIDTH-1:0] c;
    logic                 fb;
    c = c_in;
    for (int unsigned i = 0; i < DWIDTH; i++) begin
      fb = c[CRC_WIDTH-1] ^ d[DWIDTH-1-i];
      c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (CRC_POLY & {CRC_WIDTH{fb}});
    end
    return c;
  endfunction

  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [CRC_WIDTH-1:0]      crc_q, crc_d;
  logic                      isdata_q, isdata_d;
  logic [FRAME_ID_WIDTH-1:0] fid_cur_q, fid_cur_d;
  logic [FRAME_ID_WIDTH-1:0] frame_id_q, frame_id_d;
  logic [DWIDTH-1:0]         data_out_q, data_out_d;
  logic                      sof_out_q, sof_out_d;
  logic                      valid_out_q, valid_out_d;

  logic                      first, tail, in_frame;
  logic [DWIDTH-1:0]         beat_masked;
  logic [CRC_WIDTH-1:0]      crc_base, crc_new, fid_ext;

  // Frame tracking, CRC accumulation, vcode insertion and frame ID update.
  always_comb begin
    first       = 1'b0;
    tail        = 1'b0;
    in_frame    = 1'b0;
    cnt_d       = '0;
    if (SINGLE) begin
      first    = tx_up;
      tail     = tx_up;
      in_frame = tx_up;
    end else begin
      first    = sof & tx_up;
      in_frame = tx_up & (first | (cnt_q != '0));
      tail     = tx_up & ~first & (cnt_q == '1);
      if (!tx_up)             cnt_d = '0;
      else if (first)         cnt_d = CNT_WIDTH'(1);
      else if (cnt_q != '0)   cnt_d = cnt_q + CNT_WIDTH'(1);
      else                    cnt_d = '0;
    end

    // Header and ID are taken from the first beat; later beats reuse the latch
    // so a rewind during the frame cannot change the ID it carries.
    isdata_d  = first ? (data_in[DWIDTH-1 -: 2] == 2'b01) : isdata_q;
    fid_cur_d = first ? frame_id_q : fid_cur_q;
    fid_ext   = CRC_WIDTH'(fid_cur_d);

    beat_masked = data_in;
    if (tail) beat_masked[CRC_WIDTH-1:0] = '0;
    crc_base = first ? '0 : crc_q;
    crc_new  = crc_step(crc_base, beat_masked);
    crc_d    = (in_frame && !tail) ? crc_new : '0;

    if (!tx_up)
      data_out_d = data_out_q;
    else if (tail)
      data_out_d = {data_in[DWIDTH-1:CRC_WIDTH], crc_new ^ fid_ext};
    else
      data_out_d = data_in;
    sof_out_d   = sof & tx_up;
    valid_out_d = tx_up;

    if (rewind)                frame_id_d = rewind_id;
    else if (tail && isdata_d) frame_id_d = frame_id_q + FRAME_ID_WIDTH'(1);
    else                       frame_id_d = frame_id_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      crc_q       <= '0;
      isdata_q    <= 1'b0;
      fid_cur_q   <= '0;
      frame_id_q  <= '0;
      data_out_q  <= '0;
      sof_out_q   <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      isdata_q    <= isdata_d;
      fid_cur_q   <= fid_cur_d;
      frame_id_q  <= frame_id_d;
      data_out_q  <= data_out_d;
      sof_out_q   <= sof_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign sof_out   = sof_out_q;
  assign valid_out = valid_out_q;
  assign frame_id  = frame_id_q;

endmodule

// File: tb/tb_vcode_gen.sv
// Directed bench for vcode_gen: 4-beat instance (256/64) and a single-beat
// instance (64/64), checked with immediate assertions against a bitwise CRC.
module tb_vcode_gen;

  logic        clk = 1'b0;
  logic        rst;
  // 4-beat instance
  logic        tx_up, sof, rewind;
  logic [63:0] data_in;
  logic [7:0]  rewind_id;
  logic [63:0] data_out;
  logic        sof_out, valid_out;
  logic [7:0]  frame_id;
  // single-beat instance
  logic        s_tx_up, s_sof, s_rewind;
  logic [63:0] s_data_in;
  logic [7:0]  s_rewind_id;
  logic [63:0] s_data_out;
  logic        s_sof_out, s_valid_out;
  logic [7:0]  s_frame_id;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vcode_gen #(.FRAME_WIDTH(256), .DWIDTH(64), .CRC_WIDTH(12),
              .CRC_POLY(12'h02f), .FRAME_ID_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .tx_up(tx_up), .sof(sof), .data_in(data_in),
    .rewind(rewind), .rewind_id(rewind_id), .data_out(data_out),
    .sof_out(sof_out), .valid_out(valid_out), .frame_id(frame_id));

  vcode_gen #(.FRAME_WIDTH(64), .DWIDTH(64), .CRC_WIDTH(12),
              .CRC_POLY(12'h02f), .FRAME_ID_WIDTH(8)) u_single (
    .clk(clk), .rst(rst), .tx_up(s_tx_up), .sof(s_sof), .data_in(s_data_in),
    .rewind(s_rewind), .rewind_id(s_rewind_id), .data_out(s_data_out),
    .sof_out(s_sof_out), .valid_out(s_valid_out), .frame_id(s_frame_id));

  // Reference CRC over the low n bits of v, MSB first, starting from zero.
  function automatic logic [11:0] crc_ref(input logic [255:0] v, input int n);
    logic [11:0] c;
    logic        fb;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[11] ^ v[i];
      c  = {c[10:0], 1'b0};
      if (fb) c = c ^ 12'h02f;
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sends one 4-beat frame; optional rewind pulse on beat rw_beat.
  // Returns the tail's low 12 bits.
  task automatic frame4(input string tag, input logic [255:0] f, input logic [7:0] fid,
                        input int rw_beat, input logic [7:0] rw_id,
                        output logic [11:0] tail_lo);
    logic [255:0] fm;
    logic [63:0]  d, exp;
    fm = f;
    fm[11:0] = '0;
    for (int b = 0; b < 4; b++) begin
      d = f[255 - 64*b -: 64];
      tx_up = 1'b1; sof = (b == 0); data_in = d;
      rewind = (b == rw_beat); rewind_id = rw_id;
      @(posedge clk); #1;
      exp = d;
      if (b == 3) exp[11:0] = crc_ref(fm, 256) ^ {4'h0, fid};
      check({tag, "_data"}, data_out, exp);
      check({tag, "_valid"}, {63'd0, valid_out}, 64'd1);
      check({tag, "_sof"}, {63'd0, sof_out}, {63'd0, b == 0});
      rewind = 1'b0;
    end
    tail_lo = data_out[11:0];
    sof = 1'b0;
  endtask

  task automatic idle_cycle();
    tx_up = 1'b0; sof = 1'b0; rewind = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [255:0] pay, pay2;
  logic [11:0]  t1, t2;
  logic [63:0]  last, d;

  initial begin
    rst = 1'b1; tx_up = 1'b0; sof = 1'b0; rewind = 1'b0; rewind_id = '0; data_in = '0;
    s_tx_up = 1'b0; s_sof = 1'b0; s_rewind = 1'b0; s_rewind_id = '0; s_data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", data_out, 64'd0);
    check("rst_valid", {63'd0, valid_out}, 64'd0);
    check("rst_sof", {63'd0, sof_out}, 64'd0);
    check("rst_fid", {56'd0, frame_id}, 64'd0);
    check("rst_s_fid", {56'd0, s_frame_id}, 64'd0);
    rst = 1'b0;

    // All-zero idle frame: CRC is zero, vcode is just the ID (0).
    frame4("idle0", 256'd0, 8'h00, -1, 8'h00, t1);
    check("idle0_tail", {52'd0, t1}, 64'h000);
    check("idle0_fid", {56'd0, frame_id}, 64'd0);

    // Two identical data frames: vcodes differ only by the ID step.
    pay = {2'b01, 254'h0};
    pay[253:0] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    frame4("data_a", pay, 8'h00, -1, 8'h00, t1);
    frame4("data_b", pay, 8'h01, -1, 8'h00, t2);
    check("data_delta", {52'd0, t1 ^ t2}, 64'h001);
    check("data_fid", {56'd0, frame_id}, 64'd2);

    // Control frame carries ID 2 but does not advance it.
    pay2 = {2'b10, 254'h0};
    pay2[127:0] = {$urandom, $urandom, $urandom, $urandom};
    frame4("ctrl", pay2, 8'h02, -1, 8'h00, t1);
    check("ctrl_fid", {56'd0, frame_id}, 64'd2);
    frame4("data_c", pay, 8'h02, -1, 8'h00, t1);
    check("data_c_fid", {56'd0, frame_id}, 64'd3);

    // Rewind during an idle frame: in-flight frame keeps ID 3.
    frame4("rw_mid", 256'd0, 8'h03, 2, 8'h05, t1);
    check("rw_mid_tail", {52'd0, t1}, 64'h003);
    check("rw_mid_fid", {56'd0, frame_id}, 64'd5);
    frame4("rw_next", 256'd0, 8'h05, -1, 8'h00, t1);
    check("rw_next_tail", {52'd0, t1}, 64'h005);

    // Rewind on the data tail beat wins over the increment.
    frame4("rw_tail", pay, 8'h05, 3, 8'h05, t1);
    check("rw_tail_fid", {56'd0, frame_id}, 64'd5);

    // Wrap-around of the frame ID counter.
    frame4("wrap_set", 256'd0, 8'h05, 0, 8'hFE, t1);
    frame4("wrap_fe", pay, 8'hFE, -1, 8'h00, t1);
    frame4("wrap_ff", pay, 8'hFF, -1, 8'h00, t1);
    check("wrap_fid0", {56'd0, frame_id}, 64'd0);
    frame4("wrap_00", pay, 8'h00, -1, 8'h00, t1);
    check("wrap_fid1", {56'd0, frame_id}, 64'd1);

    // sof restart after two beats: vcode covers the new frame only.
    for (int b = 0; b < 2; b++) begin
      d = pay2[255 - 64*b -: 64];
      tx_up = 1'b1; sof = (b == 0); data_in = d;
      @(posedge clk); #1;
      check("restart_pass", data_out, d);
    end
    frame4("restart", pay, 8'h01, -1, 8'h00, t1);
    check("restart_fid", {56'd0, frame_id}, 64'd2);

    // tx_up low: valid drops, data_out holds its last value.
    last = data_out;
    tx_up = 1'b0; data_in = 64'hDEAD_BEEF_0000_1111;
    @(posedge clk); #1;
    check("down_valid", {63'd0, valid_out}, 64'd0);
    check("down_hold", data_out, last);
    idle_cycle();

    // Single-beat mode: each valid beat is a whole frame.
    s_tx_up = 1'b1; s_sof = 1'b0; s_data_in = 64'h0;
    @(posedge clk); #1;
    check("s_idle", s_data_out, 64'h0);
    check("s_idle_fid", {56'd0, s_frame_id}, 64'd0);
    d = {2'b01, 62'h0};
    d[61:12] = {$urandom, $urandom};
    d[11:0] = 12'hABC;
    s_data_in = d;
    @(posedge clk); #1;
    check("s_data0", s_data_out, {d[63:12], crc_ref({192'd0, d[63:12], 12'h000}, 64) ^ 12'h000});
    check("s_fid1", {56'd0, s_frame_id}, 64'd1);
    @(posedge clk); #1;
    check("s_data1", s_data_out, {d[63:12], crc_ref({192'd0, d[63:12], 12'h000}, 64) ^ 12'h001});
    s_tx_up = 1'b0;
    @(posedge clk); #1;
    check("s_down_valid", {63'd0, s_valid_out}, 64'd0);
    check("s_down_fid", {56'd0, s_frame_id}, 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
